// File: rtl/game_engine.sv
// game_engine: game state machine, bird physics, N-deep scrolling pipe queue with collision,
// and score/high-score tracking; all game state advances once per new_frame tick.
module game_engine #(
   parameter int NUM_PIPES    = 3,
   parameter int W            = 16,
   parameter int SCORE_W      = 10,
   parameter int SCROLL_SPEED = 5,
   parameter int GRAVITY      = 1,
   parameter int FLAP_SPEED   = 13,
   parameter int MAX_FALL     = 16,
   parameter int PIPE_PERIOD  = 64,
   parameter int GAP_BASE     = 420,
   parameter int SPAWN_Y      = 480,
   parameter int BIRD_Y       = 100,
   parameter int GROUND_X     = 104,
   parameter int CEIL_X       = 728,
   parameter int GAP_LO       = 80,
   parameter int GAP_HI       = 220,
   parameter int HIT_NEG      = 96,
   parameter int HIT_POS      = 60
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   new_frame,
   input  logic                   button_pulse,
   input  logic                   pause_pulse,
   input  logic [7:0]             random,
   output logic [2:0]             game_state,
   output logic signed [W-1:0]    bird_pos_x,
   output logic signed [W-1:0]    bird_vel,
   output logic [NUM_PIPES*W-1:0] pipe_pos_x,
   output logic [NUM_PIPES*W-1:0] pipe_pos_y,
   output logic [SCORE_W-1:0]     score,
   output logic [SCORE_W-1:0]     high_score,
   output logic                   hit
);
   typedef enum logic [2:0] {START = 3'd0, READY = 3'd1, FLY = 3'd2, PAUSE = 3'd3, OVER = 3'd4} state_e;
   typedef logic signed [W:0] wide_t;
   localparam int CW = PIPE_PERIOD > 1 ? $clog2(PIPE_PERIOD) : 1;
   localparam int PW = $clog2(NUM_PIPES + 1);
   localparam wide_t GND = wide_t'(GROUND_X);
   localparam wide_t CEIL = wide_t'(CEIL_X);
   localparam wide_t THR = wide_t'(BIRD_Y - HIT_NEG);
   localparam logic signed [W-1:0] READY_X = W'(420);
   localparam logic signed [W-1:0] READY_PX = W'(500);
   localparam logic signed [W-1:0] IDLE_Y = W'(-120);

   state_e                state_q;
   logic                  btn_q, pse_q, frame_q, hit_q, btn, pse, hit_now, spawn;
   logic [CW-1:0]         cnt_q;
   logic signed [W-1:0]   pos_q, vel_q, pos_d, vel_d;
   logic signed [W-1:0]   px_q [NUM_PIPES];
   logic signed [W-1:0]   py_q [NUM_PIPES];
   logic signed [W-1:0]   py_d [NUM_PIPES];
   logic [SCORE_W-1:0]    score_q, high_q, score_d;
   logic [PW-1:0]         passes;
   logic [SCORE_W+PW-1:0] sum;
   wide_t                 vf, nx, dx, dy;

   // Pulses arriving with the tick count immediately; the latch keeps earlier ones until then.
   always_comb begin
      btn = btn_q | button_pulse;
      pse = pse_q | pause_pulse;
      vf = wide_t'(vel_q) - wide_t'(GRAVITY);
      vf = btn && state_q == FLY ? wide_t'(FLAP_SPEED) : vf < -wide_t'(MAX_FALL) ? -wide_t'(MAX_FALL) : vf;
      nx = wide_t'(pos_q) + vf;
      pos_d = nx > CEIL ? W'(CEIL) : nx < GND ? W'(GND) : W'(nx);
      vel_d = nx < GND ? '0 : W'(vf);
      spawn = cnt_q == '0;
      hit_now = wide_t'(pos_q) <= GND;
      passes = '0;
      dx = '0;
      dy = '0;
      for (int k = 0; k < NUM_PIPES; k++) begin
         dy = wide_t'(py_q[k]) - wide_t'(BIRD_Y);
         dx = wide_t'(px_q[k]) - wide_t'(pos_q);
         py_d[k] = py_q[k] - W'(SCROLL_SPEED);
         if (dy >= -wide_t'(HIT_NEG) && dy <= wide_t'(HIT_POS) && (dx < wide_t'(GAP_LO) || dx > wide_t'(GAP_HI)))
            hit_now = 1'b1;
         if (wide_t'(py_q[k]) >= THR && wide_t'(py_q[k]) - wide_t'(SCROLL_SPEED) < THR)
            passes = passes + PW'(1);
      end
      sum = (SCORE_W+PW)'(score_q) + (SCORE_W+PW)'(passes);
      score_d = |sum[SCORE_W+PW-1:SCORE_W] ? '1 : sum[SCORE_W-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= START;
         btn_q   <= 1'b0;
         pse_q   <= 1'b0;
         frame_q <= 1'b0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
         pos_q   <= '0;
         vel_q   <= '0;
         score_q <= '0;
         high_q  <= '0;
         for (int k = 0; k < NUM_PIPES; k++) begin
            px_q[k] <= '0;
            py_q[k] <= IDLE_Y;
         end
      end else begin
         frame_q <= new_frame;
         btn_q   <= (btn_q & ~frame_q) | button_pulse;
         pse_q   <= (pse_q & ~frame_q) | pause_pulse;
         if (new_frame) begin
            hit_q <= state_q == FLY && hit_now;
            case (state_q)
               START, READY: begin
                  state_q <= btn ? (state_q == START ? READY : FLY) : state_q;
                  if (state_q == START && btn) score_q <= '0;
                  pos_q <= READY_X;
                  vel_q <= '0;
                  cnt_q <= '0;
                  for (int k = 0; k < NUM_PIPES; k++) begin
                     px_q[k] <= READY_PX;
                     py_q[k] <= IDLE_Y;
                  end
               end
               FLY: begin
                  state_q <= hit_now ? OVER : pse ? PAUSE : FLY;
                  pos_q <= pos_d;
                  vel_q <= vel_d;
                  cnt_q <= cnt_q == CW'(PIPE_PERIOD - 1) ? '0 : cnt_q + CW'(1);
                  for (int k = 0; k < NUM_PIPES - 1; k++) begin
                     px_q[k] <= spawn ? px_q[k + 1] : px_q[k];
                     py_q[k] <= spawn ? py_d[k + 1] : py_d[k];
                  end
                  px_q[NUM_PIPES - 1] <= spawn ? W'(GAP_BASE) + W'(random) : px_q[NUM_PIPES - 1];
                  py_q[NUM_PIPES - 1] <= spawn ? W'(SPAWN_Y) : py_d[NUM_PIPES - 1];
                  if (!hit_now) score_q <= score_d;
                  if (hit_now && score_q > high_q) high_q <= score_q;
               end
               PAUSE: state_q <= pse ? FLY : PAUSE;
               OVER: begin
                  state_q <= btn ? START : OVER;
                  if (wide_t'(pos_q) > GND) begin
                     pos_q <= pos_d;
                     vel_q <= vel_d;
                  end
               end
               default: state_q <= START;
            endcase
         end
      end
   end

   assign game_state = state_q;
   assign bird_pos_x = pos_q;
   assign bird_vel   = vel_q;
   assign score      = score_q;
   assign high_score = high_q;
   assign hit        = hit_q;

   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
      assign pipe_pos_x[i*W +: W] = px_q[i];
      assign pipe_pos_y[i*W +: W] = py_q[i];
   end
endmodule

// File: tb/tb_game_engine.sv
// tb_game_engine: randomized scoreboard bench for game_engine, checked against a
// frame-level reference model of the game rules.
module tb_game_engine;
   localparam int N = 3;
   localparam int W = 16;
   localparam int SW = 3;  // narrow score so saturation is reachable in a short run
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic new_frame = 1'b0;
   logic button_pulse = 1'b0;
   logic pause_pulse = 1'b0;
   logic chk_req = 1'b0;
   logic [7:0] random = 8'd0;
   logic [2:0] game_state;
   logic [W-1:0] bird_pos_x, bird_vel;
   logic [N*W-1:0] pipe_pos_x, pipe_pos_y;
   logic [SW-1:0] score, high_score;
   logic hit;

   game_engine #(.NUM_PIPES(N), .W(W), .SCORE_W(SW)) dut (
      .clk(clk), .rstn(rstn), .new_frame(new_frame), .button_pulse(button_pulse),
      .pause_pulse(pause_pulse), .random(random), .game_state(game_state),
      .bird_pos_x(bird_pos_x), .bird_vel(bird_vel), .pipe_pos_x(pipe_pos_x),
      .pipe_pos_y(pipe_pos_y), .score(score), .high_score(high_score), .hit(hit)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]     st;
      logic [W-1:0]   pos;
      logic [W-1:0]   vel;
      logic [N*W-1:0] px;
      logic [N*W-1:0] py;
      logic [SW-1:0]  sc;
      logic [SW-1:0]  hi;
      logic           ht;
   } snap_t;

   snap_t exp_q[$];
   int m_st, m_pos, m_vel, m_cnt, m_score, m_high, m_hit;
   int mpx[$];
   int mpy[$];
   int n_chk = 0;
   int n_pass = 0;
   int n_evt = 0;

   task automatic model_reset();
      m_st = 0; m_pos = 0; m_vel = 0; m_cnt = 0; m_score = 0; m_high = 0; m_hit = 0;
      mpx = {};
      mpy = {};
      repeat (N) begin
         mpx.push_back(0);
         mpy.push_back(-120);
      end
   endtask

   task automatic fly(input bit flap);
      int v, nx;
      v = flap ? 13 : (m_vel - 1 < -16 ? -16 : m_vel - 1);
      nx = m_pos + v;
      if (nx > 728) begin m_pos = 728; m_vel = v; end
      else if (nx < 104) begin m_pos = 104; m_vel = 0; end
      else begin m_pos = nx; m_vel = v; end
   endtask

   task automatic model_frame(input bit b, input bit p, input int rnd);
      bit hn;
      int pass, ns;
      hn = m_pos <= 104;
      pass = 0;
      foreach (mpy[k]) begin
         if (mpy[k] - 100 >= -96 && mpy[k] - 100 <= 60 && (mpx[k] - m_pos < 80 || mpx[k] - m_pos > 220)) hn = 1;
         if (mpy[k] >= 4 && mpy[k] - 5 < 4) pass++;
      end
      m_hit = 0;
      ns = m_st;
      case (m_st)
         0, 1: begin
            if (b) begin
               ns = m_st + 1;
               if (m_st == 0) m_score = 0;
            end
            m_pos = 420; m_vel = 0; m_cnt = 0;
            foreach (mpx[k]) begin mpx[k] = 500; mpy[k] = -120; end
         end
         2: begin
            m_hit = hn;
            ns = hn ? 4 : (p ? 3 : 2);
            fly(b);
            foreach (mpy[k]) mpy[k] -= 5;
            if (m_cnt == 0) begin
               void'(mpx.pop_front());
               void'(mpy.pop_front());
               mpx.push_back(420 + rnd);
               mpy.push_back(480);
            end
            m_cnt = (m_cnt + 1) % 64;
            if (hn) m_high = m_score > m_high ? m_score : m_high;
            else m_score = m_score + pass > SMAX ? SMAX : m_score + pass;
         end
         3: if (p) ns = 2;
         default: begin
            if (m_pos > 104) fly(1'b0);
            if (b) ns = 0;
         end
      endcase
      m_st = ns;
   endtask

   function automatic snap_t snap();
      snap_t s;
      s.st = 3'(m_st);
      s.pos = W'(m_pos);
      s.vel = W'(m_vel);
      for (int k = 0; k < N; k++) begin
         s.px[k*W +: W] = W'(mpx[k]);
         s.py[k*W +: W] = W'(mpy[k]);
      end
      s.sc = SW'(m_score);
      s.hi = SW'(m_high);
      s.ht = m_hit[0];
      return s;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s event %0d: got %0h expected %0h", nm, n_evt, act, exp);
   endtask

   task automatic compare(input snap_t e);
      cmp("game_state", 64'(game_state), 64'(e.st));
      cmp("bird_pos_x", 64'(bird_pos_x), 64'(e.pos));
      cmp("bird_vel", 64'(bird_vel), 64'(e.vel));
      cmp("pipe_pos_x", 64'(pipe_pos_x), 64'(e.px));
      cmp("pipe_pos_y", 64'(pipe_pos_y), 64'(e.py));
      cmp("score", 64'(score), 64'(e.sc));
      cmp("high_score", 64'(high_score), 64'(e.hi));
      cmp("hit", 64'(hit), 64'(e.ht));
   endtask

   // Monitor: every frame tick or explicit reset probe consumes one expected snapshot.
   initial forever begin
      @(posedge clk or posedge chk_req);
      if (new_frame || chk_req) begin
         #1;
         n_evt++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty event %0d: got an update, expected none pending", n_evt);
         end else compare(exp_q.pop_front());
      end
   end

   task automatic frame(input bit b, input bit p, input bit co, input int r);
      if (!co) begin
         @(negedge clk);
         button_pulse = b;
         pause_pulse = p;
      end
      @(negedge clk);
      button_pulse = co & b;
      pause_pulse = co & p;
      random = 8'(r);
      new_frame = 1'b1;
      model_frame(b, p, r);
      exp_q.push_back(snap());
      @(negedge clk);
      new_frame = 1'b0;
      button_pulse = 1'b0;
      pause_pulse = 1'b0;
   endtask

   // Reset is probed before the next rising edge, so only an asynchronous clear satisfies it.
   task automatic reset_check();
      @(negedge clk);
      #2 rstn = 1'b0;
      model_reset();
      exp_q.push_back(snap());
      #1 chk_req = 1'b1;
      #1 chk_req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int tx, ty, r;
      bit b, p, co;
      reset_check();
      repeat (3) frame(0, 0, 0, 0);
      frame(1, 0, 0, 0);
      frame(1, 0, 0, 0);
      frame(1, 0, 0, 32);
      frame(0, 0, 0, 0);
      repeat (3) frame(0, 0, 0, $urandom_range(0, 255));
      frame(0, 1, 0, 0);
      repeat (10) frame(1'($urandom_range(0, 1)), 0, 0, 0);
      frame(0, 1, 0, 0);
      repeat (3) frame(0, 0, 0, 0);
      repeat (120) frame(0, 0, 0, $urandom_range(0, 255));
      frame(1, 0, 0, 0);
      frame(1, 0, 1, 0);
      frame(1, 0, 1, 0);
      frame(0, 0, 0, 7);
      repeat (4) frame(1, 0, 0, 0);
      reset_check();
      repeat (2000) begin
         r = $urandom_range(0, 255);
         co = 1'($urandom_range(0, 1));
         b = 0;
         p = 0;
         if (m_st == 2) begin
            ty = 1 << 30;
            tx = 0;
            foreach (mpy[k]) if (mpy[k] >= 4 && mpy[k] < ty) begin ty = mpy[k]; tx = mpx[k]; end
            b = (m_pos < tx - 195 && m_vel < 4) || $urandom_range(0, 99) == 0;
            p = $urandom_range(0, 149) == 0;
         end else if (m_st == 3) begin
            b = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 3) == 0;
         end else b = $urandom_range(0, 2) == 0;
         frame(b, p, co, r);
      end
      repeat (4) @(posedge clk);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
